fft_frame_loader: RTL and testbench
===================================

# fft_frame_loader

Front end for the 16-point FFT core. Accepts a serial stream of signed audio samples, assembles 16-sample frames in two ping-pong banks, and stores each sample at its bit-reversed slot so the FFT's first stage pairs the correct inputs. Each full frame is presented as sixteen 36-bit complex words, and the loader issues a one-cycle `fft_start`. It holds the frame stable until the FFT's `done` rises, so sample capture continues while a transform runs.

## Interface
- `SAMPLE_W`, 16: incoming sample width, signed, ≤ 18.
- `PRESCALE`, 4: arithmetic right shift applied to each real part; gives headroom for 4 stages of butterfly growth.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_in`  in  SAMPLE_W  signed audio sample.
- `sample_valid`  in  1  `sample_in` is valid this cycle; no backpressure.
- `fft_done`  in  1  `done` level from the FFT core.
- `fft_start`  out  1  single-cycle start pulse to the FFT.
- `fft_in0` … `fft_in15`  out  36 each  complex word: real in [35:18], imag in [17:0]; imag is always 0.
- `busy`  out  1  a frame is handed to the FFT and not yet released.
- `overrun`  out  1  sticky; set when a sample is dropped; cleared only by reset.
- `frame_cnt`  out  16  completed transforms; wraps at 65535→0.

## Operation
- Real-part formatting:
  - left-justify `sample_in` into 18 bits by appending (18−SAMPLE_W) zeros;
  - then shift right arithmetically by `PRESCALE`;
  - the result is stored as an 18-bit two's-complement value.
- Write side (two banks, 0 and 1):
  - `wr_bank` and `wr_idx` are 0..15;
  - an accepted sample k goes to slot `bitrev4(k)` of `wr_bank`;
  - when `wr_idx`=15 is written, that bank is marked full, `wr_idx` wraps to 0 and `wr_bank` toggles.
- Bank blocking and overrun:
  - if the target bank is still full (not released), `sample_valid` samples are dropped and `overrun` is set;
  - writing resumes at slot index 0 of that bank, frame-aligned, once it is released.
- Present side FSM:
  - IDLE: a full bank exists → latch `rd_bank` = oldest full bank, go to START.
  - START: `fft_start`=1 for exactly one cycle, then go to WAIT.
  - WAIT: on a rising edge of `fft_done` (against a registered previous value): release `rd_bank` (mark empty), increment `frame_cnt`, go to IDLE.
- `busy` = state ≠ IDLE.
- `fft_inj` is driven combinationally from slot j of `rd_bank`; a bank is never written while it is `rd_bank` and full.

## Timing
- Reset values:
  - `fft_start`=0, `busy`=0, `overrun`=0, `frame_cnt`=0;
  - all bank slots 0, so every `fft_inj`=0;
  - FSM in IDLE, `wr_idx`=0, `wr_bank`=0, `rd_bank`=0;
  - both banks empty; done-edge register 0.
- Start latency: the 16th sample is captured at edge E. The FSM enters START at E+1, so `fft_start` is high during cycle E+1→E+2. `fft_in*` is stable from E+1.
- A stale high `fft_done` from a previous run never counts as completion. Only a 0→1 transition seen while in WAIT releases the bank.
- After release, the FSM spends one cycle in IDLE before the next START. So the minimum spacing between `fft_start` pulses is the FFT latency plus 2 cycles.
- Simultaneous events in the same cycle:
  - done edge and a bank completing: release happens first; the completed bank starts from IDLE on the next cycle;
  - sample arriving in the release cycle: the bank is still full, so the sample is dropped and `overrun` is set.
- Reset mid-operation: everything returns to reset values immediately. A partial frame is discarded, and any in-flight FFT result is not counted.

## Structure
- Package `fft_pkg`:
  - constants `FFT_N`=16, `CPLX_W`=36, `HALF_W`=18;
  - the W_k/16 twiddle constants;
  - function `bitrev4`;
  - a complex struct with `re`/`im` fields.
  - The FFT core and this loader share it.
- Sub-module `fft_sample_bank`:
  - 16×18 register file;
  - one write port (slot index, data, enable);
  - async clear;
  - 16 parallel read outputs.
  - Instantiated twice.

## Test plan
1. Assert reset → all outputs 0, `fft_in0`..`fft_in15`=0, `busy`=0.
2. Feed samples k·1024 for k=0..15 (SAMPLE_W=16, PRESCALE=4) → one `fft_start` pulse the cycle after the 16th sample, with:
   - `fft_in0`=0;
   - `fft_in1`={18'h00800, 18'h0} (holds k=8);
   - `fft_in15`={18'h00F00, 18'h0}.
3. First sample 16'h8000 → `fft_in0` real = 18'h3E000, imag = 0.
4. 32 back-to-back samples; FFT model drops `done` after start and raises it 6 cycles later →
   - second `fft_start` arrives only after the first done rising edge plus 1 idle cycle;
   - `frame_cnt`=2 after both runs;
   - `overrun`=0.
5. 48 samples with the model never raising `done` → samples 33–48 dropped, `overrun`=1. Raise `done` → bank 0 is released, and the next sample is written to bank 0 slot 0.
6. Reset after 7 samples of a frame → state is cleared; the next 16 samples form a complete frame and produce exactly one `fft_start`.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT core and its frame loader.
package fft_pkg;

  localparam int FFT_N   = 16;
  localparam int CPLX_W  = 36;
  localparam int HALF_W  = 18;
  localparam int TW_FRAC = 16;  // twiddles are Q1.16, 1.0 = 65536

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } cplx_t;

  // Presentation FSM of the loader.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } loader_state_t;

  // W_16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), k = 0..7.
  localparam cplx_t TWIDDLE [FFT_N/2] = '{
    '{re:  18'sd65536, im:  18'sd0},
    '{re:  18'sd60547, im: -18'sd25080},
    '{re:  18'sd46341, im: -18'sd46341},
    '{re:  18'sd25080, im: -18'sd60547},
    '{re:  18'sd0,     im: -18'sd65536},
    '{re: -18'sd25080, im: -18'sd60547},
    '{re: -18'sd46341, im: -18'sd46341},
    '{re: -18'sd60547, im: -18'sd25080}
  };

  // Reverse the 4 index bits (radix-2 input ordering).
  function automatic logic [3:0] bitrev4(input logic [3:0] idx);
    return {idx[0], idx[1], idx[2], idx[3]};
  endfunction

endpackage

// File: rtl/fft_sample_bank.sv
// One 16 x 18 sample register file: single write port, all slots readable in parallel.
module fft_sample_bank
  import fft_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [3:0]                     wr_slot,
  input  logic [HALF_W-1:0]              wr_data,
  output logic [FFT_N-1:0][HALF_W-1:0]   rd_slots
);

  logic [FFT_N-1:0][HALF_W-1:0] slot_q;
  logic [FFT_N-1:0][HALF_W-1:0] slot_d;

  // Next contents: only the addressed slot changes on a write.
  always_comb begin
    slot_d = slot_q;
    if (wr_en) begin
      slot_d[wr_slot] = wr_data;
    end
  end

  // Slot storage, cleared to zero on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign rd_slots = slot_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader: gathers 16 samples per bank in bit-reversed order and
// hands full banks to the FFT core with a start pulse, holding them until done.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                fft_done,
  output logic                fft_start,
  output logic [CPLX_W-1:0]   fft_in0,
  output logic [CPLX_W-1:0]   fft_in1,
  output logic [CPLX_W-1:0]   fft_in2,
  output logic [CPLX_W-1:0]   fft_in3,
  output logic [CPLX_W-1:0]   fft_in4,
  output logic [CPLX_W-1:0]   fft_in5,
  output logic [CPLX_W-1:0]   fft_in6,
  output logic [CPLX_W-1:0]   fft_in7,
  output logic [CPLX_W-1:0]   fft_in8,
  output logic [CPLX_W-1:0]   fft_in9,
  output logic [CPLX_W-1:0]   fft_in10,
  output logic [CPLX_W-1:0]   fft_in11,
  output logic [CPLX_W-1:0]   fft_in12,
  output logic [CPLX_W-1:0]   fft_in13,
  output logic [CPLX_W-1:0]   fft_in14,
  output logic [CPLX_W-1:0]   fft_in15,
  output logic                busy,
  output logic                overrun,
  output logic [15:0]         frame_cnt
);

  loader_state_t state_q, state_d;
  logic          wr_bank_q, wr_bank_d;
  logic [3:0]    wr_idx_q, wr_idx_d;
  logic [1:0]    full_q, full_d, full_set, full_clr;
  logic          rd_bank_q, rd_bank_d;
  logic          done_prev_q, done_prev_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [HALF_W-1:0]            left_just;
  logic signed [HALF_W-1:0]     real_fmt;
  logic                         wr_accept;
  logic [FFT_N-1:0][HALF_W-1:0] bank_slots [2];
  cplx_t                        rd_word [FFT_N];

  // Left-justify into 18 bits, then pre-scale for butterfly growth.
  assign left_just = HALF_W'(sample_in) << (HALF_W - SAMPLE_W);
  assign real_fmt  = $signed(left_just) >>> PRESCALE;

  // A sample is dropped whenever its target bank still holds an unreleased frame.
  assign wr_accept = sample_valid && !full_q[wr_bank_q];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      fft_sample_bank u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_accept && (wr_bank_q == 1'(gi))),
        .wr_slot  (bitrev4(wr_idx_q)),
        .wr_data  (real_fmt),
        .rd_slots (bank_slots[gi])
      );
    end
    for (genvar gi = 0; gi < FFT_N; gi++) begin : g_word
      assign rd_word[gi] = '{re: bank_slots[rd_bank_q][gi], im: '0};
    end
  endgenerate

  // Write side: advance the slot index, mark a bank full on its 16th sample.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    overrun_d = overrun_q;
    full_set  = '0;
    if (sample_valid && !wr_accept) begin
      overrun_d = 1'b1;
    end else if (wr_accept) begin
      if (wr_idx_q == 4'd15) begin
        full_set[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
        wr_idx_d            = 4'd0;
      end else begin
        wr_idx_d = wr_idx_q + 4'd1;
      end
    end
  end

  // Present side: pick a full bank, pulse start, release on a fresh done edge.
  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    full_clr    = '0;
    fft_start   = 1'b0;
    done_prev_d = fft_done;
    case (state_q)
      ST_IDLE: begin
        if (|full_q) begin
          // With both banks full the one blocking the writer is the older one.
          rd_bank_d = (&full_q) ? wr_bank_q : full_q[1];
          state_d   = ST_START;
        end
      end
      ST_START: begin
        fft_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (fft_done && !done_prev_q) begin
          full_clr[rd_bank_q] = 1'b1;
          frame_cnt_d         = frame_cnt_q + 16'd1;
          state_d             = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The writer never targets the bank being released, so set and clear never collide.
  assign full_d = (full_q | full_set) & ~full_clr;

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= 4'd0;
      full_q      <= 2'b00;
      rd_bank_q   <= 1'b0;
      done_prev_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      full_q      <= full_d;
      rd_bank_q   <= rd_bank_d;
      done_prev_q <= done_prev_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

  assign fft_in0  = rd_word[0];
  assign fft_in1  = rd_word[1];
  assign fft_in2  = rd_word[2];
  assign fft_in3  = rd_word[3];
  assign fft_in4  = rd_word[4];
  assign fft_in5  = rd_word[5];
  assign fft_in6  = rd_word[6];
  assign fft_in7  = rd_word[7];
  assign fft_in8  = rd_word[8];
  assign fft_in9  = rd_word[9];
  assign fft_in10 = rd_word[10];
  assign fft_in11 = rd_word[11];
  assign fft_in12 = rd_word[12];
  assign fft_in13 = rd_word[13];
  assign fft_in14 = rd_word[14];
  assign fft_in15 = rd_word[15];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: per-cycle comparison against a frame-level model,
// a formatting vector table, and directed corner-case sequences.
module tb_fft_frame_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        fft_done;
  logic        fft_start;
  logic [35:0] fft_in0, fft_in1, fft_in2, fft_in3, fft_in4, fft_in5, fft_in6, fft_in7;
  logic [35:0] fft_in8, fft_in9, fft_in10, fft_in11, fft_in12, fft_in13, fft_in14, fft_in15;
  logic        busy;
  logic        overrun;
  logic [15:0] frame_cnt;
  logic [575:0] dut_words;

  fft_frame_loader #(.SAMPLE_W(16), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .fft_done(fft_done), .fft_start(fft_start),
    .fft_in0(fft_in0), .fft_in1(fft_in1), .fft_in2(fft_in2), .fft_in3(fft_in3),
    .fft_in4(fft_in4), .fft_in5(fft_in5), .fft_in6(fft_in6), .fft_in7(fft_in7),
    .fft_in8(fft_in8), .fft_in9(fft_in9), .fft_in10(fft_in10), .fft_in11(fft_in11),
    .fft_in12(fft_in12), .fft_in13(fft_in13), .fft_in14(fft_in14), .fft_in15(fft_in15),
    .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  assign dut_words = {fft_in15, fft_in14, fft_in13, fft_in12, fft_in11, fft_in10, fft_in9, fft_in8,
                      fft_in7, fft_in6, fft_in5, fft_in4, fft_in3, fft_in2, fft_in1, fft_in0};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int start_cyc[$];
  int first_rise = -1;

  // FFT responder
  bit auto_fft = 0;
  bit rand_lat = 0;
  int lat_fixed = 6;
  int lat_cnt = 0;
  logic done_drv = 1'b0;

  // Reference model: banks hold samples in arrival order; slot j shows sample brev(j).
  logic [17:0] mdata [2][16];
  bit   m_full [2];
  int   m_wb, m_wi, m_hb;
  bit   m_handed, m_start, m_dprev, m_ovr;
  logic [15:0] m_frames;
  int   pend[$];

  typedef struct {
    logic [15:0] smp;
    logic [17:0] re;
  } vec_t;
  vec_t tbl [16];

  function automatic int brev(input int j);
    return ((j & 1) << 3) | ((j & 2) << 1) | ((j & 4) >> 1) | ((j & 8) >> 3);
  endfunction

  // 16-bit sample -> 18-bit value scaled by 4, then divided by 16 rounding toward -inf.
  function automatic logic [17:0] fmt(input logic [15:0] s);
    int v;
    v = int'($signed(s)) * 4;
    v = v >>> 4;
    return 18'(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_full[b] = 0;
      for (int k = 0; k < 16; k++) mdata[b][k] = '0;
    end
    m_wb = 0; m_wi = 0; m_hb = 0;
    m_handed = 0; m_start = 0; m_dprev = 0; m_ovr = 0;
    m_frames = '0;
    pend.delete();
  endtask

  task automatic model_edge(input logic v, input logic [15:0] s, input logic d);
    bit rel, st;
    rel = m_handed && !m_start && d && !m_dprev;
    st  = !m_handed && (pend.size() > 0);
    if (v) begin
      if (m_full[m_wb]) m_ovr = 1;
      else begin
        mdata[m_wb][m_wi] = fmt(s);
        if (m_wi == 15) begin
          m_full[m_wb] = 1;
          pend.push_back(m_wb);
          m_wb = 1 - m_wb;
          m_wi = 0;
        end else m_wi++;
      end
    end
    if (rel) begin
      m_full[m_hb] = 0;
      m_frames = m_frames + 16'd1;
      m_handed = 0;
    end
    m_start = 0;
    if (st) begin
      m_hb = pend.pop_front();
      m_handed = 1;
      m_start = 1;
    end
    m_dprev = d;
  endtask

  task automatic check_model();
    logic [575:0] exp_words;
    for (int j = 0; j < 16; j++) exp_words[j*36 +: 36] = {mdata[m_hb][brev(j)], 18'h0};
    chk("fft_start", 64'(fft_start), 64'(m_start));
    chk("busy", 64'(busy), 64'(m_handed));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
    chk_w("fft_in", dut_words, exp_words);
  endtask

  // One clock: drive inputs, advance model, observe outputs mid-cycle.
  task automatic step(input logic v, input logic [15:0] s);
    if (auto_fft) begin
      if (fft_start) begin
        done_drv = 1'b0;
        lat_cnt  = rand_lat ? int'($urandom_range(1, 30)) : lat_fixed;
      end else if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          done_drv = 1'b1;
          if (first_rise < 0) first_rise = cyc + 1;
        end
      end
    end
    sample_valid = v;
    sample_in    = s;
    fft_done     = done_drv;
    model_edge(v, s, done_drv);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_model();
    if (fft_start) begin
      starts++;
      start_cyc.push_back(cyc);
      $display("frame start: cycle %0d frame_cnt %0d", cyc, frame_cnt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    fft_done = done_drv;
    #1;
    model_reset();
    check_model();  // asynchronous: cleared before any clock edge
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0; starts = 0; lat_cnt = 0; first_rise = -1;
    start_cyc.delete();
  endtask

  initial begin
    tbl[0]  = '{16'h8000, 18'h3E000};
    tbl[1]  = '{16'h7FFF, 18'h01FFF};
    tbl[2]  = '{16'hFFFF, 18'h3FFFF};
    tbl[3]  = '{16'h2000, 18'h00800};
    tbl[4]  = '{16'h3C00, 18'h00F00};
    tbl[5]  = '{16'h0001, 18'h00000};
    tbl[6]  = '{16'h0010, 18'h00004};
    tbl[7]  = '{16'hFFF0, 18'h3FFFC};
    tbl[8]  = '{16'hC000, 18'h3F000};
    tbl[9]  = '{16'h4000, 18'h01000};
    tbl[10] = '{16'h0000, 18'h00000};
    tbl[11] = '{16'h1234, 18'h0048D};
    tbl[12] = '{16'hF000, 18'h3FC00};
    tbl[13] = '{16'h0100, 18'h00040};
    tbl[14] = '{16'h8001, 18'h3E000};
    tbl[15] = '{16'h0400, 18'h00100};

    reset = 1'b0; sample_valid = 1'b0; sample_in = '0; fft_done = 1'b0;

    // 1. reset state
    do_reset();
    chk("rst_start", 64'(fft_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk_w("rst_words", dut_words, 576'd0);

    // 2. ramp k*1024, start the cycle after the 16th sample
    for (int k = 0; k < 16; k++) step(1'b1, 16'(k * 1024));
    chk("ramp_no_early_start", 64'(fft_start), 64'd0);
    step(1'b0, 16'h0);
    chk("ramp_start", 64'(fft_start), 64'd1);
    chk("ramp_in0", 64'(fft_in0), 64'd0);
    chk("ramp_in1", 64'(fft_in1), {28'd0, 18'h00800, 18'h0});
    chk("ramp_in15", 64'(fft_in15), {28'd0, 18'h00F00, 18'h0});
    step(1'b0, 16'h0);
    chk("ramp_start_one_cycle", 64'(fft_start), 64'd0);

    // 3. formatting table, including 16'h8000 as the first sample
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b1, tbl[k].smp);
    step(1'b0, 16'h0);
    chk("tbl_start", 64'(fft_start), 64'd1);
    for (int k = 0; k < 16; k++) begin
      int j;
      j = brev(k);
      chk($sformatf("tbl_word%0d", j), 64'(dut_words[j*36 +: 36]), {28'd0, tbl[k].re, 18'h0});
    end

    // 4. back-to-back frames, done stale high at first, 6-cycle FFT
    done_drv = 1'b1;
    do_reset();
    auto_fft = 1; rand_lat = 0; lat_fixed = 6;
    for (int k = 0; k < 32; k++) step(1'b1, 16'($urandom));
    for (int k = 0; k < 25; k++) step(1'b0, 16'h0);
    chk("b2b_starts", 64'(starts), 64'd2);
    chk("b2b_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("b2b_overrun", 64'(overrun), 64'd0);

    // 4b. long FFT: second start exactly one idle cycle after the done edge
    done_drv = 1'b0;
    do_reset();
    lat_fixed = 20;
    for (int k = 0; k < 32; k++) step(1'b1, 16'($urandom));
    for (int k = 0; k < 50; k++) step(1'b0, 16'h0);
    chk("long_starts", 64'(starts), 64'd2);
    if (start_cyc.size() >= 2) chk("long_spacing", 64'(start_cyc[1]), 64'(first_rise + 1));
    auto_fft = 0;

    // 5. FFT never finishes: third frame dropped, then release and resume at bank 0
    done_drv = 1'b0;
    do_reset();
    for (int k = 0; k < 32; k++) step(1'b1, 16'(k * 16'h0101));
    chk("ovr_clear_32", 64'(overrun), 64'd0);
    for (int k = 32; k < 48; k++) step(1'b1, 16'(k * 16'h0101));
    chk("ovr_set_48", 64'(overrun), 64'd1);
    done_drv = 1'b1;
    step(1'b1, 16'h7777);  // release cycle: this sample is dropped
    for (int k = 0; k < 16; k++) step(1'b1, 16'((k + 1) * 16'h0100));
    done_drv = 1'b0;
    step(1'b0, 16'h0);
    done_drv = 1'b1;
    step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    chk("resume_start", 64'(fft_start), 64'd1);
    chk("resume_in0", 64'(fft_in0), {28'd0, 18'h00040, 18'h0});
    chk("resume_in8", 64'(fft_in8), {28'd0, 18'h00080, 18'h0});
    chk("resume_frame_cnt", 64'(frame_cnt), 64'd2);

    // 6. reset mid-frame discards the partial frame
    done_drv = 1'b0;
    do_reset();
    for (int k = 0; k < 7; k++) step(1'b1, 16'h1111);
    do_reset();
    chk_w("midrst_words", dut_words, 576'd0);
    for (int k = 0; k < 16; k++) step(1'b1, 16'(16'h0200 + k));
    for (int k = 0; k < 10; k++) step(1'b0, 16'h0);
    chk("midrst_starts", 64'(starts), 64'd1);
    chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);

    // 7. random traffic with random FFT latency
    done_drv = 1'b0;
    do_reset();
    auto_fft = 1; rand_lat = 1;
    for (int k = 0; k < 1000; k++) step(($urandom_range(0, 9) < 7), 16'($urandom));
    auto_fft = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
